uart_core: RTL and testbench



---
 rtl/uart_core.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// UART transceiver: programmable divisor and framing, 3-sample majority-vote receiver,
// and show-ahead TX/RX FIFOs with valid/ready handshakes and per-byte error flags.
module uart_core #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [DIV_W-1:0]            cfg_div_i,
    input  logic [1:0]                  cfg_dbits_i,
    input  logic [1:0]                  cfg_parity_i,
    input  logic                        cfg_stop2_i,
    input  logic [7:0]                  tx_data_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    output logic [7:0]                  rx_data_o,
    output logic                        rx_perr_o,
    output logic                        rx_ferr_o,
    output logic                        rx_valid_o,
    input  logic                        rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0] rx_level_o,
    output logic                        ovr_o,
    input  logic                        ovr_clr_i,
    output logic                        tx_busy_o,
    output logic                        tx_o,
    input  logic                        rx_i
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = $clog2(OVERSAMPLE);
    localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] SMP_A   = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] SMP_B   = OW'(OVERSAMPLE / 2);
    localparam logic [OW-1:0] SMP_C   = OW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] DEPTH   = CW'(FIFO_DEPTH);

    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    function automatic logic [7:0] dmask(input logic [1:0] dbits);
        return 8'hFF >> (2'd3 - dbits);
    endfunction

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [CW-1:0] tx_cnt, tx_cnt_next;
    logic [7:0]    tx_head;
    logic          tx_push, tx_pop;

    assign tx_push     = tx_valid_i && tx_ready_o;
    assign tx_head     = tx_mem[tx_rp];
    assign tx_cnt_next = tx_cnt + CW'(tx_push) - CW'(tx_pop);

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp] <= tx_data_i;
    end

    // ---------------- TX FSM ----------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    tx_state_t        tx_state, tx_state_next;
    logic [DIV_W-1:0] tx_div, tx_dcnt;
    logic [OW-1:0]    tx_os;
    logic [7:0]       tx_shift;
    logic [2:0]       tx_idx, tx_nlast;
    logic             tx_par_en, tx_stop2, tx_par;
    logic             tx_tick, tx_bit_end, tx_bit;

    assign tx_tick    = (tx_dcnt == tx_div - DIV_W'(1));
    assign tx_bit_end = tx_tick && (tx_os == OS_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) tx_state <= TX_IDLE;
        else       tx_state <= tx_state_next;
    end

    // Last stop bit chains straight into the next frame when a byte is waiting.
    always_comb begin
        tx_state_next = tx_state;
        tx_pop        = 1'b0;
        tx_bit        = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (tx_cnt != '0) begin
                    tx_pop        = 1'b1;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                tx_bit = 1'b0;
                if (tx_bit_end) tx_state_next = TX_DATA;
            end
            TX_DATA: begin
                tx_bit = tx_shift[0];
                if (tx_bit_end && tx_idx == tx_nlast)
                    tx_state_next = tx_par_en ? TX_PARITY : TX_STOP1;
            end
            TX_PARITY: begin
                tx_bit = tx_par;
                if (tx_bit_end) tx_state_next = TX_STOP1;
            end
            TX_STOP1, TX_STOP2: begin
                if (tx_bit_end) begin
                    if (tx_state == TX_STOP1 && tx_stop2) begin
                        tx_state_next = TX_STOP2;
                    end else if (tx_cnt != '0) begin
                        tx_pop        = 1'b1;
                        tx_state_next = TX_START;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wp      <= '0;
            tx_rp      <= '0;
            tx_cnt     <= '0;
            tx_ready_o <= 1'b1;
            tx_busy_o  <= 1'b0;
            tx_o       <= 1'b1;
            tx_div     <= DIV_W'(1);
            tx_dcnt    <= '0;
            tx_os      <= '0;
            tx_shift   <= '0;
            tx_idx     <= '0;
            tx_nlast   <= '0;
            tx_par_en  <= 1'b0;
            tx_stop2   <= 1'b0;
            tx_par     <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            tx_cnt     <= tx_cnt_next;
            tx_ready_o <= (tx_cnt_next != DEPTH);
            tx_busy_o  <= (tx_state_next != TX_IDLE) || (tx_cnt_next != '0);
            tx_o       <= tx_bit;
            if (tx_pop) begin
                // Frame start: capture config and restart the baud counter.
                tx_div    <= eff_div(cfg_div_i);
                tx_dcnt   <= '0;
                tx_os     <= '0;
                tx_shift  <= tx_head & dmask(cfg_dbits_i);
                tx_idx    <= '0;
                tx_nlast  <= 3'd4 + 3'(cfg_dbits_i);
                tx_par_en <= (cfg_parity_i == 2'd1) || (cfg_parity_i == 2'd2);
                tx_par    <= (^(tx_head & dmask(cfg_dbits_i))) ^ (cfg_parity_i == 2'd2);
                tx_stop2  <= cfg_stop2_i;
            end else begin
                tx_dcnt <= tx_tick ? '0 : tx_dcnt + DIV_W'(1);
                if (tx_tick) tx_os <= (tx_os == OS_LAST) ? '0 : tx_os + OW'(1);
                if (tx_state == TX_DATA && tx_bit_end) begin
                    tx_shift <= tx_shift >> 1;
                    tx_idx   <= tx_idx + 3'd1;
                end
            end
        end
    end

    // ---------------- RX FSM ----------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    rx_state_t        rx_state, rx_state_next;
    logic             rx_s1, rx_s2, rx_s3;
    logic [DIV_W-1:0] rx_div, rx_dcnt;
    logic [OW-1:0]    rx_os;
    logic [1:0]       rx_votes;
    logic [7:0]       rx_shift;
    logic [2:0]       rx_idx, rx_nlast;
    logic             rx_par_en, rx_odd, rx_perr;
    logic             rx_tick, rx_bit_end, rx_decide, rx_smp, rx_start_det, rx_push;

    assign rx_start_det = rx_s3 && !rx_s2;
    assign rx_tick      = (rx_dcnt == rx_div - DIV_W'(1));
    assign rx_bit_end   = rx_tick && (rx_os == OS_LAST);
    assign rx_decide    = rx_tick && (rx_os == SMP_C);
    assign rx_smp       = (rx_votes + 2'(rx_s2)) >= 2'd2;

    always_ff @(posedge clk_i) begin
        if (rst_i) rx_state <= RX_IDLE;
        else       rx_state <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_push       = 1'b0;
        case (rx_state)
            RX_IDLE:   if (rx_start_det) rx_state_next = RX_START;
            RX_START: begin
                if (rx_decide && rx_smp) rx_state_next = RX_IDLE;
                else if (rx_bit_end)     rx_state_next = RX_DATA;
            end
            RX_DATA: begin
                if (rx_bit_end && rx_idx == rx_nlast)
                    rx_state_next = rx_par_en ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_bit_end) rx_state_next = RX_STOP;
            RX_STOP: begin
                if (rx_decide) begin
                    rx_push       = 1'b1;
                    rx_state_next = rx_smp ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: if (rx_s2) rx_state_next = RX_IDLE;
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_s3     <= 1'b1;
            rx_div    <= DIV_W'(1);
            rx_dcnt   <= '0;
            rx_os     <= '0;
            rx_votes  <= '0;
            rx_shift  <= '0;
            rx_idx    <= '0;
            rx_nlast  <= '0;
            rx_par_en <= 1'b0;
            rx_odd    <= 1'b0;
            rx_perr   <= 1'b0;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            if (rx_state == RX_IDLE && rx_start_det) begin
                rx_div    <= eff_div(cfg_div_i);
                rx_dcnt   <= '0;
                rx_os     <= '0;
                rx_shift  <= '0;
                rx_idx    <= '0;
                rx_nlast  <= 3'd4 + 3'(cfg_dbits_i);
                rx_par_en <= (cfg_parity_i == 2'd1) || (cfg_parity_i == 2'd2);
                rx_odd    <= (cfg_parity_i == 2'd2);
                rx_perr   <= 1'b0;
            end else begin
                rx_dcnt <= rx_tick ? '0 : rx_dcnt + DIV_W'(1);
                if (rx_tick) begin
                    rx_os <= (rx_os == OS_LAST) ? '0 : rx_os + OW'(1);
                    if (rx_os == SMP_A) rx_votes <= 2'(rx_s2);
                    if (rx_os == SMP_B) rx_votes <= rx_votes + 2'(rx_s2);
                end
                if (rx_state == RX_DATA && rx_decide)   rx_shift[rx_idx] <= rx_smp;
                if (rx_state == RX_DATA && rx_bit_end)  rx_idx <= rx_idx + 3'd1;
                if (rx_state == RX_PARITY && rx_decide) rx_perr <= rx_smp ^ (^rx_shift) ^ rx_odd;
            end
        end
    end

    // ---------------- RX FIFO ({perr, ferr, data}) ----------------
    logic [9:0]    rx_mem [FIFO_DEPTH];
    logic [9:0]    rx_wdata, rx_head_next;
    logic [AW-1:0] rx_wp, rx_rp, rx_rp_next;
    logic [CW-1:0] rx_cnt, rx_cnt_next;
    logic          rx_pop, rx_full, rx_wr, ovr_set;

    assign rx_wdata    = {rx_perr, !rx_smp, rx_shift};
    assign rx_pop      = rx_valid_o && rx_ready_i;
    assign rx_full     = (rx_cnt == DEPTH);
    assign rx_wr       = rx_push && (!rx_full || rx_pop);
    assign ovr_set     = rx_push && rx_full && !rx_pop;
    assign rx_cnt_next = rx_cnt + CW'(rx_wr) - CW'(rx_pop);
    assign rx_rp_next  = rx_rp + AW'(rx_pop);

    // Registered show-ahead head; bypass the write when it lands at the new head.
    always_comb begin
        rx_head_next = '0;
        if (rx_cnt_next != '0) begin
            if (rx_wr && rx_rp_next == rx_wp) rx_head_next = rx_wdata;
            else                              rx_head_next = rx_mem[rx_rp_next];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_wr) rx_mem[rx_wp] <= rx_wdata;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_wp      <= '0;
            rx_rp      <= '0;
            rx_cnt     <= '0;
            rx_valid_o <= 1'b0;
            rx_level_o <= '0;
            rx_data_o  <= '0;
            rx_perr_o  <= 1'b0;
            rx_ferr_o  <= 1'b0;
            ovr_o      <= 1'b0;
        end else begin
            if (rx_wr) rx_wp <= rx_wp + AW'(1);
            rx_rp      <= rx_rp_next;
            rx_cnt     <= rx_cnt_next;
            rx_valid_o <= (rx_cnt_next != '0);
            rx_level_o <= rx_cnt_next;
            rx_data_o  <= rx_head_next[7:0];
            rx_ferr_o  <= rx_head_next[8];
            rx_perr_o  <= rx_head_next[9];
            if (ovr_set)        ovr_o <= 1'b1;
            else if (ovr_clr_i) ovr_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core: loopback and bench-driven frames at
// 432 clk/bit, break, false start, overrun, and mid-frame reset.
module tb_uart_core;
    localparam int BIT = 432;

    logic       clk = 1'b0;
    logic       rst;
    logic [15:0] cfg_div;
    logic [1:0] cfg_dbits, cfg_parity;
    logic       cfg_stop2;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_perr, rx_ferr, rx_valid, rx_ready;
    logic [4:0] rx_level;
    logic       ovr, ovr_clr, tx_busy, tx_line, rx_line;
    logic       loop, drv;

    int n_checks = 0;
    int n_errors = 0;
    int t = 0;
    logic [15:0] fr;

    always #10 clk = ~clk;
    assign rx_line = loop ? tx_line : drv;

    uart_core dut (
        .clk_i(clk), .rst_i(rst), .cfg_div_i(cfg_div), .cfg_dbits_i(cfg_dbits),
        .cfg_parity_i(cfg_parity), .cfg_stop2_i(cfg_stop2), .tx_data_i(tx_data),
        .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .rx_data_o(rx_data),
        .rx_perr_o(rx_perr), .rx_ferr_o(rx_ferr), .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready), .rx_level_o(rx_level), .ovr_o(ovr), .ovr_clr_i(ovr_clr),
        .tx_busy_o(tx_busy), .tx_o(tx_line), .rx_i(rx_line)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance to 1 time unit after edge e, counted from the last write edge.
    task automatic goto(input int e);
        repeat (e - t) @(posedge clk);
        #1;
        t = e;
    endtask

    task automatic write_tx(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 20000) begin
            @(posedge clk); #1; n++;
        end
        check("tx_ready_wait", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        t = 0;
    endtask

    task automatic pop_rx(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        int n = 0;
        while (!rx_valid && n < 20000) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_valid"}, rx_valid, 1);
        check({tag, "_data"}, rx_data, d);
        check({tag, "_perr"}, rx_perr, pe);
        check({tag, "_ferr"}, rx_ferr, fe);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while (tx_busy && n < 40000) begin
            @(posedge clk); #1; n++;
        end
        check("tx_idle_wait", tx_busy, 0);
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            drv = bits[i];
            repeat (BIT) @(posedge clk);
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; cfg_div = 16'd27; cfg_dbits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; ovr_clr = 1'b0; loop = 1'b1; drv = 1'b1;
        idle(3);
        check("rst_tx", tx_line, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_perr", rx_perr, 0);
        check("rst_ferr", rx_ferr, 0);
        check("rst_level", rx_level, 0);
        check("rst_ovr", ovr, 0);
        check("rst_busy", tx_busy, 0);
        rst = 1'b0;
        idle(5);

        // 8N1 0xA5 loopback
        write_tx(8'hA5);
        goto(1); check("t1_pre_start", tx_line, 1);
        goto(2); check("t1_start_edge", tx_line, 0);
        fr = {6'b0, 1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            goto(2 + BIT * k + BIT / 2);
            check($sformatf("t1_bit%0d", k), tx_line, fr[k]);
        end
        // start seen 3 clk after tx falls; stop sample = tick 153 -> push edge 5+27*154
        goto(4162); check("t1_valid_before", rx_valid, 0);
        goto(4163); check("t1_valid_rise", rx_valid, 1);
        goto(4320); check("t1_busy_end", tx_busy, 1);
        goto(4330); check("t1_busy_done", tx_busy, 0);
        pop_rx("t1", 8'hA5, 1'b0, 1'b0);

        // 7E2 back-to-back 0x3F, 0x41
        cfg_dbits = 2'd2; cfg_parity = 2'd1; cfg_stop2 = 1'b1;
        idle(5);
        write_tx(8'h3F);
        write_tx(8'h41);
        t = 1;
        fr = {5'b0, 2'b11, 1'b0, 7'h3F, 1'b0};
        for (int k = 0; k < 11; k++) begin
            goto(2 + BIT * k + BIT / 2);
            check($sformatf("t2a_bit%0d", k), tx_line, fr[k]);
        end
        goto(4753); check("t2_gap_stop", tx_line, 1);
        goto(4754); check("t2_gap_start", tx_line, 0);
        fr = {5'b0, 2'b11, 1'b0, 7'h41, 1'b0};
        for (int k = 0; k < 11; k++) begin
            goto(4754 + BIT * k + BIT / 2);
            check($sformatf("t2b_bit%0d", k), tx_line, fr[k]);
        end
        pop_rx("t2a", 8'h3F, 1'b0, 1'b0);
        pop_rx("t2b", 8'h41, 1'b0, 1'b0);
        wait_tx_idle();

        // odd parity, bench-driven 0x55 with wrong parity bit 0
        cfg_dbits = 2'd3; cfg_parity = 2'd2; cfg_stop2 = 1'b0;
        drv = 1'b1; loop = 1'b0;
        idle(20);
        drive_bits({5'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
        drv = 1'b1;
        pop_rx("t3", 8'h55, 1'b1, 1'b0);

        // break: 0x00 with stop held low 3000 clk
        cfg_parity = 2'd0;
        idle(500);
        drive_bits(16'h0000, 9);
        drv = 1'b0;
        idle(3000);
        drv = 1'b1;
        idle(2000);
        check("t4_level_one", rx_level, 1);
        pop_rx("t4", 8'h00, 1'b0, 1'b1);
        idle(500);
        check("t4_no_second", rx_valid, 0);

        // overrun at div=4 (64 clk/bit)
        cfg_div = 16'd4; loop = 1'b1;
        idle(20);
        for (int i = 0; i < 17; i++) write_tx(8'(8'h10 + i));
        wait_tx_idle();
        idle(200);
        check("t5_level_full", rx_level, 16);
        check("t5_ovr_set", ovr, 1);
        ovr_clr = 1'b1; idle(1); ovr_clr = 1'b0;
        check("t5_ovr_clr", ovr, 0);
        for (int i = 0; i < 16; i++) pop_rx($sformatf("t5_b%0d", i), 8'(8'h10 + i), 1'b0, 1'b0);
        check("t5_byte17_lost", rx_valid, 0);
        for (int i = 0; i < 16; i++) write_tx(8'(8'h30 + i));
        wait_tx_idle();
        idle(200);
        check("t5_refill_level", rx_level, 16);
        // push lands at edge 5+4*154 after the write; pop in that same cycle
        write_tx(8'h55);
        goto(620); rx_ready = 1'b1;
        goto(621); rx_ready = 1'b0;
        idle(2);
        check("t5_popwr_ovr", ovr, 0);
        check("t5_popwr_level", rx_level, 16);
        for (int i = 1; i < 16; i++) pop_rx($sformatf("t5_r%0d", i), 8'(8'h30 + i), 1'b0, 1'b0);
        pop_rx("t5_last", 8'h55, 1'b0, 1'b0);
        check("t5_drained", rx_valid, 0);

        // false start from a 200-clk glitch
        cfg_div = 16'd27; drv = 1'b1; loop = 1'b0;
        idle(20);
        drv = 1'b0; idle(200); drv = 1'b1;
        idle(1500);
        check("t6_glitch_valid", rx_valid, 0);
        check("t6_glitch_level", rx_level, 0);

        // reset mid-frame
        loop = 1'b1;
        idle(10);
        write_tx(8'hC3);
        write_tx(8'h3C);
        t = 1;
        goto(100);
        check("t7_mid_start", tx_line, 0);
        check("t7_mid_busy", tx_busy, 1);
        rst = 1'b1;
        idle(1);
        check("t7_rst_tx", tx_line, 1);
        check("t7_rst_busy", tx_busy, 0);
        check("t7_rst_ready", tx_ready, 1);
        check("t7_rst_level", rx_level, 0);
        rst = 1'b0;
        idle(6000);
        check("t7_no_byte", rx_valid, 0);
        check("t7_line_idle", tx_line, 1);
        check("t7_tx_idle", tx_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
